// File: rtl/round_key_buffer.sv
// Round-key store: in-order fill from key expansion, registered random-access read.
// Optional RKB_ZEROIZE_EN: flush scrubs storage one entry per cycle before refilling.
module round_key_buffer #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_valid,
    input  logic [3:0]   wr_round,
    input  logic [127:0] wr_key,
    output logic         wr_ready,
    input  logic         flush,
    input  logic         rd_en,
    input  logic [3:0]   rd_round,
    output logic [127:0] rd_key,
    output logic         rd_valid,
    output logic         full,
    output logic         wr_err
);

    localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

`ifdef RKB_ZEROIZE_EN
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2,
        ZEROIZE = 2'd3
    } state_t;
    localparam state_t FLUSH_TGT = ZEROIZE;
`else
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } state_t;
    localparam state_t FLUSH_TGT = EMPTY;
`endif

    state_t state;
    state_t state_nxt;

    logic [127:0]        mem [0:NUM_ROUNDS];
    logic [NUM_ROUNDS:0] vld;
    logic [3:0]          exp_idx;
    logic                in_order;
    logic                wr_ok;
    logic                wr_bad;
    logic                rd_hit;
    logic                zeroizing;

`ifdef RKB_ZEROIZE_EN
    logic [3:0] z_idx;
    logic       z_last;
    assign zeroizing = (state == ZEROIZE);
    assign z_last    = (z_idx == LAST);
`else
    assign zeroizing = 1'b0;
`endif

    assign in_order = (wr_round == exp_idx) && (wr_round <= LAST);
    assign wr_ok    = wr_valid && wr_ready && !flush && in_order;
    assign wr_bad   = wr_valid && wr_ready && !flush && !in_order;
    assign rd_hit   = (rd_round <= LAST) && vld[rd_round] && !zeroizing;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY, FILLING: begin
                if (flush) begin
                    state_nxt = FLUSH_TGT;
                end else if (wr_ok) begin
                    state_nxt = (wr_round == LAST) ? FULL : FILLING;
                end
            end
            FULL: begin
                if (flush) begin
                    state_nxt = FLUSH_TGT;
                end
            end
`ifdef RKB_ZEROIZE_EN
            ZEROIZE: begin
                if (flush) begin
                    state_nxt = ZEROIZE;
                end else if (z_last) begin
                    state_nxt = EMPTY;
                end
            end
`endif
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        wr_ready = (state == EMPTY) || (state == FILLING);
        full     = (state == FULL);
    end

    // flush takes priority over any write in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                mem[i] <= '0;
            end
            vld     <= '0;
            exp_idx <= '0;
            wr_err  <= 1'b0;
`ifdef RKB_ZEROIZE_EN
            z_idx   <= '0;
`endif
        end else if (flush) begin
            vld     <= '0;
            exp_idx <= '0;
            wr_err  <= 1'b0;
`ifdef RKB_ZEROIZE_EN
            z_idx   <= '0;
`endif
        end else begin
            if (wr_ok) begin
                mem[wr_round] <= wr_key;
                vld[wr_round] <= 1'b1;
                exp_idx       <= exp_idx + 4'd1;
            end
            if (wr_bad) begin
                wr_err <= 1'b1;
            end
`ifdef RKB_ZEROIZE_EN
            if (zeroizing) begin
                mem[z_idx] <= '0;
                z_idx      <= z_idx + 4'd1;
            end
`endif
        end
    end

    // reads see pre-edge storage, so same-cycle writes/flush are not visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_key   <= '0;
            rd_valid <= 1'b0;
        end else if (rd_en) begin
            rd_valid <= rd_hit;
            rd_key   <= rd_hit ? mem[rd_round] : '0;
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_round_key_buffer.sv
// Scoreboard bench for round_key_buffer: directed FIPS-197 fill plus random traffic
// checked against an array/queue reference model.
module tb_round_key_buffer;

    localparam int NR = 10;
`ifdef RKB_ZEROIZE_EN
    localparam bit ZEN = 1'b1;
`else
    localparam bit ZEN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         wr_valid = 1'b0;
    logic [3:0]   wr_round = '0;
    logic [127:0] wr_key = '0;
    logic         wr_ready;
    logic         flush = 1'b0;
    logic         rd_en = 1'b0;
    logic [3:0]   rd_round = '0;
    logic [127:0] rd_key;
    logic         rd_valid;
    logic         full;
    logic         wr_err;

    round_key_buffer #(.NUM_ROUNDS(NR)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_round(wr_round), .wr_key(wr_key),
        .wr_ready(wr_ready), .flush(flush),
        .rd_en(rd_en), .rd_round(rd_round),
        .rd_key(rd_key), .rd_valid(rd_valid),
        .full(full), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [127:0] fips [0:NR];
    initial begin
        fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    end

    // reference model
    logic [127:0] m_key [0:NR];
    bit           m_vld [0:NR];
    int           m_next = 0;
    bit           m_full = 1'b0;
    bit           m_err = 1'b0;
    int           m_zcnt = 0;

    logic [128:0] exp_q [$];
    bit           pend = 1'b0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic bit m_ready();
        return !m_full && (m_zcnt == 0);
    endfunction

    task automatic model_clear();
        for (int i = 0; i <= NR; i++) m_vld[i] = 1'b0;
        m_next = 0;
        m_full = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_edge();
        bit rdy;
        if (!rst_n) return;
        if (rd_en) begin
            if (int'(rd_round) <= NR && m_zcnt == 0 && m_vld[rd_round])
                exp_q.push_back({1'b1, m_key[rd_round]});
            else
                exp_q.push_back('0);
        end
        rdy = m_ready();
        if (flush) begin
            model_clear();
            m_zcnt = ZEN ? NR + 1 : 0;
        end else begin
            if (m_zcnt > 0) m_zcnt--;
            if (wr_valid && rdy) begin
                if (int'(wr_round) == m_next) begin
                    m_key[wr_round] = wr_key;
                    m_vld[wr_round] = 1'b1;
                    m_next++;
                    if (m_next == NR + 1) m_full = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!wr_ready && n < 40) begin
            cyc();
            n++;
        end
        chk("wait_ready", wr_ready, 1);
    endtask

    task automatic wr(input int r, input logic [127:0] k);
        wr_valid = 1'b1;
        wr_round = 4'(r);
        wr_key   = k;
        cyc();
        wr_valid = 1'b0;
    endtask

    task automatic rd(input int r);
        rd_en    = 1'b1;
        rd_round = 4'(r);
        cyc();
        rd_en    = 1'b0;
    endtask

    // monitor
    always @(posedge clk) pend = rst_n && rd_en;

    always @(negedge clk) begin
        logic [128:0] e;
        if (rst_n) begin
            chk("full", full, m_full);
            chk("wr_ready", wr_ready, m_ready());
            chk("wr_err", wr_err, m_err);
            if (pend) begin
                if (exp_q.size() == 0) begin
                    chk("rd_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_valid", rd_valid, e[128]);
                    chk("rd_key", rd_key, e[127:0]);
                end
            end
        end
    end

    initial begin
        int n;
        model_clear();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rd_key", rd_key, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_full", full, 0);
        chk("rst_wr_err", wr_err, 0);
        chk("rst_wr_ready", wr_ready, 1);
        cyc();
        rst_n = 1'b1;
        cyc();

        // in-order fill with overlapping same-index reads
        for (int r = 0; r <= NR; r++) begin
            rd_en    = 1'b1;
            rd_round = 4'(r);
            wr(r, fips[r]);
        end
        rd_en = 1'b0;
        chk("full_after_fill", full, 1);
        rd(10);
        chk("rd10_key", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("rd10_valid", rd_valid, 1);
        rd(1);
        chk("rd1_key", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);

        // overflow write while full
        wr(5, 128'hdeadbeef_00000000_12345678_9abcdef0);
        chk("ovf_wr_ready", wr_ready, 0);
        chk("ovf_wr_err", wr_err, 0);
        rd(5);
        chk("ovf_entry5", rd_key, fips[5]);

        // flush beats a same-cycle write
        flush = 1'b1;
        wr(3, fips[3]);
        flush = 1'b0;
        n = 0;
        while (!wr_ready && n < 30) begin
            rd_en    = 1'b1;
            rd_round = 4'(n % (NR + 1));
            cyc();
            n++;
        end
        rd_en = 1'b0;
        chk("flush_busy_cycles", n, ZEN ? NR + 1 : 0);
        for (int r = 0; r <= NR; r++) rd(r);
        wr(1, fips[1]);
        chk("after_flush_r1_err", wr_err, 1);

        // out-of-order write
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        wait_ready();
        wr(0, fips[0]);
        wr(2, fips[2]);
        chk("ooo_err", wr_err, 1);
        rd(2);
        chk("ooo_entry2_valid", rd_valid, 0);
        wr(1, fips[1]);
        rd(1);
        chk("ooo_r1_key", rd_key, fips[1]);

        // same-cycle read and first write of index 0
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        wait_ready();
        rd_en    = 1'b1;
        rd_round = 4'd0;
        wr(0, fips[0]);
        chk("same_cycle_valid", rd_valid, 0);
        cyc();
        rd_en = 1'b0;
        chk("repeat_read_key", rd_key, fips[0]);

        // out-of-range read
        rd(15);
        chk("rd15_valid", rd_valid, 0);
        chk("rd15_key", rd_key, 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_round = ($urandom_range(0, 7) == 0) ? 4'($urandom)
                                                   : 4'(m_next);
            wr_key   = {$urandom, $urandom, $urandom, $urandom};
            flush    = ($urandom_range(0, 39) == 0);
            rd_en    = ($urandom_range(0, 2) != 0);
            rd_round = ($urandom_range(0, 5) == 0) ? 4'($urandom)
                                                   : 4'($urandom_range(0, NR));
            cyc();
        end
        wr_valid = 1'b0;
        flush    = 1'b0;
        rd_en    = 1'b0;

        // asynchronous reset mid-fill
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        wait_ready();
        for (int r = 0; r <= 4; r++) wr(r, fips[r]);
        rd_en    = 1'b1;
        rd_round = 4'd3;
        #2 rst_n = 1'b0;
        pend = 1'b0;
        exp_q.delete();
        model_clear();
        m_zcnt = 0;
        #1;
        chk("amid_rd_key", rd_key, 0);
        chk("amid_rd_valid", rd_valid, 0);
        chk("amid_full", full, 0);
        chk("amid_wr_err", wr_err, 0);
        chk("amid_wr_ready", wr_ready, 1);
        rd_en = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int r = 0; r <= 4; r++) begin
            rd(r);
            chk("post_rst_valid", rd_valid, 0);
        end
        cyc();
        cyc();
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
